// File: rtl/mem_req_sched_if.sv
// rtl/mem_req_sched_if.sv - request/response bundle between the scheduler and the AXI bus controller
// master: scheduler side, which drives the registered request outputs and receives the reload pulses and result data.
// slave : bus controller side.
interface mem_req_sched_if;
  logic         ird_req;
  logic [31:0]  ird_addr;
  logic         drd_req;
  logic [31:0]  drd_addr;
  logic         dwr_req;
  logic [31:0]  dwr_addr;
  logic [255:0] dcacheline_old;
  logic         unrd_req;
  logic [31:0]  unrd_addr;
  logic         unwr_req;
  logic [3:0]   unwr_wstrb;
  logic [31:0]  unwr_addr;
  logic [31:0]  unwr_data;
  logic         i_reload;
  logic         d_reload;
  logic         un_reload;
  logic [511:0] icacheline_new;
  logic [255:0] dcacheline_new;
  logic [31:0]  unrd_data;

  modport master (
    output ird_req, ird_addr, drd_req, drd_addr, dwr_req, dwr_addr, dcacheline_old,
           unrd_req, unrd_addr, unwr_req, unwr_wstrb, unwr_addr, unwr_data,
    input  i_reload, d_reload, un_reload, icacheline_new, dcacheline_new, unrd_data
  );

  modport slave (
    input  ird_req, ird_addr, drd_req, drd_addr, dwr_req, dwr_addr, dcacheline_old,
           unrd_req, unrd_addr, unwr_req, unwr_wstrb, unwr_addr, unwr_data,
    output i_reload, d_reload, un_reload, icacheline_new, dcacheline_new, unrd_data
  );
endinterface

// File: rtl/mem_req_sched.sv
// rtl/mem_req_sched.sv - groups I-cache, D-cache and uncached requests into bus rounds
// Ports: clk/rst; ic_* I-cache refill request/ack/line; dc_* D-cache refill + victim writeback;
// uc_* uncached access; bus (master modport) controller requests, reload pulses and result data;
// err_timeout / err_spurious sticky error flags.
module mem_req_sched #(
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ic_req,
  input  logic [31:0]    ic_addr,
  output logic           ic_ack,
  output logic [511:0]   ic_line,
  input  logic           dc_rd_req,
  input  logic [31:0]    dc_rd_addr,
  input  logic           dc_wr_req,
  input  logic [31:0]    dc_wr_addr,
  input  logic [255:0]   dc_wr_line,
  output logic           dc_ack,
  output logic [255:0]   dc_line,
  input  logic           uc_req,
  input  logic           uc_we,
  input  logic [3:0]     uc_wstrb,
  input  logic [31:0]    uc_addr,
  input  logic [31:0]    uc_wdata,
  output logic           uc_ack,
  output logic [31:0]    uc_rdata,
  mem_req_sched_if.master bus,
  output logic           err_timeout,
  output logic           err_spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYC - 1);
  localparam logic [11:0] TO_MAX  = 12'(TIMEOUT_CYC);

  state_t      state, next_state;
  logic        grant, capture, any_reload;
  logic        pick_d, pick_u;
  logic        rr;
  logic        g_i, g_d, g_u, h_dwr, h_uwe;
  logic [11:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // D and U never share a round; rr only matters when both are pending
    pick_d     = dc_rd_req & (~uc_req | ~rr);
    pick_u     = uc_req & (~dc_rd_req | rr);
    any_reload = bus.i_reload | bus.d_reload | bus.un_reload;
    next_state = state;
    grant      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE:  if (ic_req | dc_rd_req | uc_req) begin
               grant      = 1'b1;
               next_state = ISSUE;
             end
      ISSUE: next_state = WAIT;
      WAIT:  if (any_reload) begin
               capture    = 1'b1;
               next_state = ACK;
             end
      ACK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr                 <= 1'b0;
      g_i                <= 1'b0;
      g_d                <= 1'b0;
      g_u                <= 1'b0;
      h_dwr              <= 1'b0;
      h_uwe              <= 1'b0;
      wait_cnt           <= '0;
      ic_ack             <= 1'b0;
      dc_ack             <= 1'b0;
      uc_ack             <= 1'b0;
      ic_line            <= '0;
      dc_line            <= '0;
      uc_rdata           <= '0;
      err_timeout        <= 1'b0;
      err_spurious       <= 1'b0;
      bus.ird_req        <= 1'b0;
      bus.ird_addr       <= '0;
      bus.drd_req        <= 1'b0;
      bus.drd_addr       <= '0;
      bus.dwr_req        <= 1'b0;
      bus.dwr_addr       <= '0;
      bus.dcacheline_old <= '0;
      bus.unrd_req       <= 1'b0;
      bus.unrd_addr      <= '0;
      bus.unwr_req       <= 1'b0;
      bus.unwr_wstrb     <= '0;
      bus.unwr_addr      <= '0;
      bus.unwr_data      <= '0;
    end else begin
      // Address/data ports double as the hold registers: loaded at grant,
      // untouched until the next grant, qualified by the request bits.
      if (grant) begin
        g_i                <= ic_req;
        g_d                <= pick_d;
        g_u                <= pick_u;
        h_dwr              <= pick_d & dc_wr_req;
        h_uwe              <= uc_we;
        if (dc_rd_req & uc_req) rr <= ~rr;
        bus.ird_addr       <= {ic_addr[31:6], 6'b0};
        bus.drd_addr       <= {dc_rd_addr[31:5], 5'b0};
        bus.dwr_addr       <= {dc_wr_addr[31:5], 5'b0};
        bus.dcacheline_old <= dc_wr_line;
        bus.unrd_addr      <= uc_addr;
        bus.unwr_addr      <= uc_addr;
        bus.unwr_wstrb     <= uc_wstrb;
        bus.unwr_data      <= uc_wdata;
      end

      if (state == ISSUE) begin
        bus.ird_req  <= g_i;
        bus.drd_req  <= g_d;
        bus.dwr_req  <= h_dwr;
        bus.unrd_req <= g_u & ~h_uwe;
        bus.unwr_req <= g_u & h_uwe;
        wait_cnt     <= '0;
      end

      // Timeout only flags; the round keeps waiting for its reload
      if (state == WAIT && !any_reload) begin
        if (wait_cnt == TO_LAST) err_timeout <= 1'b1;
        if (wait_cnt != TO_MAX)  wait_cnt    <= wait_cnt + 12'd1;
      end

      if (capture) begin
        if (g_i) ic_line  <= bus.icacheline_new;
        if (g_d) dc_line  <= bus.dcacheline_new;
        if (g_u) uc_rdata <= h_uwe ? 32'd0 : bus.unrd_data;
        bus.ird_req  <= 1'b0;
        bus.drd_req  <= 1'b0;
        bus.dwr_req  <= 1'b0;
        bus.unrd_req <= 1'b0;
        bus.unwr_req <= 1'b0;
      end

      // Acks last exactly the one cycle spent in ACK
      ic_ack <= capture & g_i;
      dc_ack <= capture & g_d;
      uc_ack <= capture & g_u;

      if (any_reload && state != WAIT) err_spurious <= 1'b1;
    end
  end

endmodule
